// File: rtl/stack_pkg.sv
// +------------------------------------------------------------------+
// | stack_pkg : shared types and defaults for the stacking-game row   |
// | lock stage.                                     Revision: 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

package stack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_LOCK  = 3'd2,
    ST_CHECK = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ROWS  = 8;
  localparam int SCORE_W   = 16;

endpackage

`default_nettype wire

// File: rtl/stack_row_lock_btn_rise_sync.sv
// +------------------------------------------------------------------+
// | btn_rise_sync : two-flop synchroniser plus registered rising-edge |
// | pulse for the raw stop button.                  Revision: 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

module btn_rise_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised level
  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn};
    rise_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

`default_nettype wire

// File: rtl/stack_row_lock.sv
// +------------------------------------------------------------------+
// | stack_row_lock : locks the moving row onto the tower, tracks the  |
// | level, flags win/over. Optional score via STACK_SCORE_EN.         |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module stack_row_lock
  import stack_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               ROWS         = DEF_ROWS,
  parameter logic [WIDTH-1:0] INIT_PATTERN = WIDTH'(8'b1110_0000)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stopBtn,
  input  logic [WIDTH-1:0]            blockLoc,
  output logic                        rowLoad,
  output logic [WIDTH-1:0]            nextBlock,
  output logic [$clog2(ROWS+1)-1:0]   level,
  output logic [ROWS*WIDTH-1:0]       stackRows,
  output logic                        gameOver,
  output logic                        gameWin
`ifdef STACK_SCORE_EN
  ,
  output logic [SCORE_W-1:0]          scoreCount
`endif
);

  localparam int LVL_W = $clog2(ROWS+1);

  logic stop_rise;

  btn_rise_sync u_btn_rise_sync (
    .clk  (clk),
    .rst  (rst),
    .btn  (stopBtn),
    .rise (stop_rise)
  );

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       held_q, held_d;
  logic [WIDTH-1:0]       prev_q, prev_d;
  logic [WIDTH-1:0]       next_q, next_d;
  logic                   load_q, load_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [ROWS*WIDTH-1:0]  rows_q, rows_d;
  logic                   over_q, over_d;
  logic                   win_q, win_d;
  logic [WIDTH-1:0]       placed;

  // held/prev stay stable through LOCK and CHECK, so placed is valid in both
  assign placed = held_q & prev_q;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    prev_d  = prev_q;
    next_d  = next_q;
    load_d  = 1'b0;
    level_d = level_q;
    rows_d  = rows_q;
    over_d  = over_q;
    win_d   = win_q;

    case (state_q)
      ST_IDLE: begin
        if (stop_rise) begin
          load_d  = 1'b1;
          next_d  = INIT_PATTERN;
          prev_d  = '1;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop_rise) begin
          held_d  = blockLoc;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        rows_d[int'(level_q)*WIDTH +: WIDTH] = placed;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (placed == '0) begin
          over_d  = 1'b1;
          state_d = ST_OVER;
        end else if (level_q == LVL_W'(ROWS-1)) begin
          level_d = LVL_W'(ROWS);
          win_d   = 1'b1;
          state_d = ST_WIN;
        end else begin
          level_d = level_q + LVL_W'(1);
          prev_d  = placed;
          next_d  = placed;
          load_d  = 1'b1;
          state_d = ST_PLAY;
        end
      end
      ST_OVER, ST_WIN: begin
        if (stop_rise) begin
          rows_d  = '0;
          level_d = '0;
          over_d  = 1'b0;
          win_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      prev_q  <= '1;
      next_q  <= INIT_PATTERN;
      load_q  <= 1'b0;
      level_q <= '0;
      rows_q  <= '0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      prev_q  <= prev_d;
      next_q  <= next_d;
      load_q  <= load_d;
      level_q <= level_d;
      rows_q  <= rows_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  assign rowLoad   = load_q;
  assign nextBlock = next_q;
  assign level     = level_q;
  assign stackRows = rows_q;
  assign gameOver  = over_q;
  assign gameWin   = win_q;

`ifdef STACK_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] pop;
  logic [SCORE_W:0]   score_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + SCORE_W'(placed[i]);
    end
    score_sum = {1'b0, score_q} + {1'b0, pop};
    score_d   = score_q;
    if (state_q == ST_CHECK && placed != '0) begin
      score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end else if ((state_q == ST_OVER || state_q == ST_WIN) && stop_rise) begin
      score_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign scoreCount = score_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_row_lock.sv
// +------------------------------------------------------------------+
// | tb_stack_row_lock : directed self-checking bench for the row lock |
// | stage (8-row and 4-row instances).              Revision: 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_stack_row_lock;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic        sel4;
  logic [7:0]  block_loc;

  logic        row_load8, over8, win8;
  logic [7:0]  next8;
  logic [3:0]  level8;
  logic [63:0] rows8;
  logic        row_load4, over4, win4;
  logic [7:0]  next4;
  logic [2:0]  level4;
  logic [31:0] rows4;
`ifdef STACK_SCORE_EN
  logic [15:0] score8, score4;
`endif

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int first, loads;

  always #5 clk = ~clk;

  stack_row_lock #(.WIDTH(8), .ROWS(8), .INIT_PATTERN(8'hE0)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .stopBtn   (btn & ~sel4),
    .blockLoc  (block_loc),
    .rowLoad   (row_load8),
    .nextBlock (next8),
    .level     (level8),
    .stackRows (rows8),
    .gameOver  (over8),
    .gameWin   (win8)
`ifdef STACK_SCORE_EN
    ,
    .scoreCount(score8)
`endif
  );

  stack_row_lock #(.WIDTH(8), .ROWS(4), .INIT_PATTERN(8'hE0)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .stopBtn   (btn & sel4),
    .blockLoc  (block_loc),
    .rowLoad   (row_load4),
    .nextBlock (next4),
    .level     (level4),
    .stackRows (rows4),
    .gameOver  (over4),
    .gameWin   (win4)
`ifdef STACK_SCORE_EN
    ,
    .scoreCount(score4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press starts just before posedge 1; i counts posedges, sampled on the following negedge.
  task automatic press(input int hold, input int repress, output int first_o, output int loads_o);
    first_o = 0;
    loads_o = 0;
    @(negedge clk);
    btn = 1'b1;
    for (int i = 1; i <= hold + 12; i++) begin
      @(negedge clk);
      if ((sel4 ? row_load4 : row_load8) === 1'b1) begin
        loads_o++;
        if (first_o == 0) first_o = i;
      end
      if (i == hold) btn = 1'b0;
      if (repress != 0 && i == repress) btn = 1'b1;
      if (repress != 0 && i == repress + 3) btn = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sel4 = 1'b0; block_loc = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rowload", {63'd0, row_load8}, 64'd0);
    check("rst_next",    {56'd0, next8},     64'hE0);
    check("rst_level",   {60'd0, level8},    64'd0);
    check("rst_rows",    rows8,              64'd0);
    check("rst_flags",   {62'd0, over8, win8}, 64'd0);
    rst = 1'b0;
    loads = 0;
    repeat (4) begin
      @(negedge clk);
      if (row_load8 === 1'b1) loads++;
    end
    check("rst_exit_noload", 64'(loads), 64'd0);

    // Start from IDLE
    press(3, 0, first, loads);
    check("t1_latency", 64'(first), 64'd4);
    check("t1_loads",   64'(loads), 64'd1);
    check("t1_next",    {56'd0, next8},  64'hE0);
    check("t1_level",   {60'd0, level8}, 64'd0);
    check("t1_flags",   {62'd0, over8, win8}, 64'd0);

    // First row kept as-is against the all-ones base
    block_loc = 8'h70;
    press(3, 0, first, loads);
    check("t2_latency", 64'(first), 64'd6);
    check("t2_loads",   64'(loads), 64'd1);
    check("t2_level",   {60'd0, level8}, 64'd1);
    check("t2_rows",    rows8, 64'h70);
    check("t2_next",    {56'd0, next8}, 64'h70);
`ifdef STACK_SCORE_EN
    check("t2_score",   {48'd0, score8}, 64'd3);
`endif

    block_loc = 8'h38;
    press(3, 0, first, loads);
    check("t3_latency", 64'(first), 64'd6);
    check("t3_level",   {60'd0, level8}, 64'd2);
    check("t3_rows",    rows8, 64'h3070);
    check("t3_next",    {56'd0, next8}, 64'h30);
`ifdef STACK_SCORE_EN
    check("t3_score",   {48'd0, score8}, 64'd5);
`endif

    // No overlap -> game over
    block_loc = 8'h0C;
    press(3, 0, first, loads);
    check("t4_loads", 64'(loads), 64'd0);
    check("t4_over",  {63'd0, over8}, 64'd1);
    check("t4_win",   {63'd0, win8},  64'd0);
    check("t4_level", {60'd0, level8}, 64'd2);
    check("t4_rows",  rows8, 64'h3070);
    press(3, 0, first, loads);
    check("t4_clr_loads", 64'(loads), 64'd0);
    check("t4_clr_over",  {63'd0, over8}, 64'd0);
    check("t4_clr_level", {60'd0, level8}, 64'd0);
    check("t4_clr_rows",  rows8, 64'd0);
`ifdef STACK_SCORE_EN
    check("t4_clr_score", {48'd0, score8}, 64'd0);
`endif

    // Held button, dropped press in CHECK, reset mid-CHECK
    press(3, 0, first, loads);
    check("t6_idle_latency", 64'(first), 64'd4);
    block_loc = 8'hFF;
    press(50, 0, first, loads);
    check("t6_held_loads", 64'(loads), 64'd1);
    check("t6_held_level", {60'd0, level8}, 64'd1);
    check("t6_held_rows",  rows8, 64'hFF);
    block_loc = 8'hF0;
    press(1, 2, first, loads);
    check("t6_drop_loads", 64'(loads), 64'd1);
    check("t6_drop_level", {60'd0, level8}, 64'd2);
    check("t6_drop_rows",  rows8, 64'hF0FF);
    block_loc = 8'h30;
    @(negedge clk);
    btn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 3) btn = 1'b0;
    end
    check("t6_mid_check_rows", rows8, 64'h30F0FF);
    rst = 1'b1;
    #2;
    check("t6_rst_level",   {60'd0, level8}, 64'd0);
    check("t6_rst_rows",    rows8, 64'd0);
    check("t6_rst_next",    {56'd0, next8}, 64'hE0);
    check("t6_rst_rowload", {63'd0, row_load8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    loads = 0;
    repeat (6) begin
      @(negedge clk);
      if (row_load8 === 1'b1) loads++;
    end
    check("t6_rst_exit_noload", 64'(loads), 64'd0);
    check("t6_rst_exit_level",  {60'd0, level8}, 64'd0);

    // 4-row tower: stack identical rows until win
    sel4 = 1'b1;
    press(3, 0, first, loads);
    check("t5_idle_latency", 64'(first), 64'd4);
    block_loc = 8'hE0;
    for (int r = 1; r <= 3; r++) begin
      press(3, 0, first, loads);
      check("t5_latency", 64'(first), 64'd6);
      check("t5_level",   {61'd0, level4}, 64'(r));
    end
    press(3, 0, first, loads);
    check("t5_win_loads", 64'(loads), 64'd0);
    check("t5_win",       {63'd0, win4}, 64'd1);
    check("t5_over",      {63'd0, over4}, 64'd0);
    check("t5_win_level", {61'd0, level4}, 64'd4);
    check("t5_win_rows",  {32'd0, rows4}, 64'hE0E0E0E0);
`ifdef STACK_SCORE_EN
    check("t5_score",     {48'd0, score4}, 64'd12);
`endif
    press(3, 0, first, loads);
    check("t5_clr_loads", 64'(loads), 64'd0);
    check("t5_clr_win",   {63'd0, win4}, 64'd0);
    check("t5_clr_level", {61'd0, level4}, 64'd0);
    check("t5_clr_rows",  {32'd0, rows4}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
